// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi arbiter: FSM state encoding and index sizing.
package quick_spi_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_SEL  = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_e;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/quick_spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module quick_spi_rr_arbiter
   import quick_spi_pkg::*;
#(
   parameter int  NUM_REQUESTERS = 4,
   localparam int IW             = idx_w(NUM_REQUESTERS)
) (
   input  logic [NUM_REQUESTERS-1:0] req,
   input  logic [IW-1:0]             ptr,
   output logic [NUM_REQUESTERS-1:0] winner,
   output logic                      any_req
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         idx = IW'((int'(ptr) + k) % NUM_REQUESTERS);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/quick_spi_arbiter.sv
// Shares one quick_spi master among requesters: round-robin grant, word capture,
// ss_n-based completion tracking with timeout, and a guard gap between transactions.
module quick_spi_arbiter
   import quick_spi_pkg::*;
#(
   parameter int NUM_REQUESTERS   = 4,
   parameter int DATA_WIDTH       = 16,
   parameter int NUMBER_OF_SLAVES = 2,
   parameter int GAP_CYCLES       = 4,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQUESTERS-1:0]              req,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0] req_slave,
   output logic [NUM_REQUESTERS-1:0]              grant,
   output logic [NUM_REQUESTERS-1:0]              done,
   output logic [NUM_REQUESTERS-1:0]              timeout_err,
   output logic                                   busy,
   output logic                                   spi_start,
   output logic [DATA_WIDTH-1:0]                  spi_data,
   output logic [NUMBER_OF_SLAVES-1:0]            spi_slave,
   input  logic [NUMBER_OF_SLAVES-1:0]            spi_ss_n
);

   localparam int IW    = idx_w(NUM_REQUESTERS);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

   state_e                        state, state_nxt;
   logic [IW-1:0]                 ptr, widx, pick_idx;
   logic [NUM_REQUESTERS-1:0]     pick_oh, win_oh;
   logic                          any_req;
   logic [DATA_WIDTH-1:0]         pick_data;
   logic [NUMBER_OF_SLAVES-1:0]   pick_slave;
   logic [TO_W-1:0]               to_cnt;
   logic [GAP_W-1:0]              gap_cnt;
   logic                          ss_idle, to_hit, gap_end;

   quick_spi_rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_rr (
      .req     (req),
      .ptr     (ptr),
      .winner  (pick_oh),
      .any_req (any_req)
   );

   // One-hot to index plus the matching request slices.
   always_comb begin
      pick_idx   = '0;
      pick_data  = '0;
      pick_slave = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (pick_oh[i]) begin
            pick_idx   = IW'(i);
            pick_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            pick_slave = req_slave[i*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
         end
      end
   end

   assign win_oh  = NUM_REQUESTERS'(1) << widx;
   assign ss_idle = &spi_ss_n;
   assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign gap_end = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      spi_start   = 1'b0;
      grant       = '0;
      done        = '0;
      timeout_err = '0;
      case (state)
         IDLE:      if (any_req) state_nxt = START;
         START: begin
            spi_start = 1'b1;
            grant     = win_oh;
            state_nxt = WAIT_SEL;
         end
         WAIT_SEL: begin
            grant = win_oh;
            if (to_hit) begin
               timeout_err = win_oh;
               state_nxt   = GAP;
            end else if (!ss_idle) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            grant = win_oh;
            // A timeout on the same cycle as ss_n rising wins: report only one outcome.
            if (to_hit) begin
               timeout_err = win_oh;
               state_nxt   = GAP;
            end else if (ss_idle) begin
               done      = win_oh;
               state_nxt = GAP;
            end
         end
         GAP:       if (gap_end) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         widx      <= '0;
         to_cnt    <= '0;
         gap_cnt   <= '0;
         spi_data  <= '0;
         spi_slave <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            widx      <= pick_idx;
            spi_data  <= pick_data;
            spi_slave <= pick_slave;
         end
         if (state == START) begin
            ptr    <= (widx == IW'(NUM_REQUESTERS - 1)) ? '0 : widx + 1'b1;
            to_cnt <= '0;
         end else if (state == WAIT_SEL || state == WAIT_DONE) begin
            to_cnt <= to_cnt + 1'b1;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      end
   end

endmodule
